// File: rtl/div_iter_if.sv
// Stream-style operand/result bundle for the iterative divider.
// The execute stage drives the master side; div_iter is the slave.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic               s_axis_divisor_tvalid;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               s_axis_dividend_tvalid;
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               m_axis_dout_tvalid;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;

  modport master (
    output s_axis_divisor_tvalid, s_axis_divisor_tdata,
    output s_axis_dividend_tvalid, s_axis_dividend_tdata,
    input  m_axis_dout_tvalid, m_axis_dout_tdata
  );

  modport slave (
    input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
    output m_axis_dout_tvalid, m_axis_dout_tdata
  );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring unsigned divider, result {quotient, remainder}.
// Optional macro DIV_EARLY_EXIT_EN skips leading-zero dividend bits and bypasses divide-by-zero.
module div_iter #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  div_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_tvalid;
  logic [2*WIDTH-1:0] r_tdata;

  logic               w_start;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH:0]     w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [2*WIDTH-1:0] w_result;
  logic [CW-1:0]      w_cnt_init;
  logic [WIDTH-1:0]   w_quo_init;
  logic               w_unused;

`ifdef DIV_EARLY_EXIT_EN
  logic               r_byp;
  logic               w_byp_init;
  logic [CW-1:0]      w_lz;

  function automatic logic [CW-1:0] clz(input logic [WIDTH-1:0] v);
    logic [CW-1:0] n;
    logic          found;
    n     = CW'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction
`endif

  assign w_start  = bus.s_axis_divisor_tvalid && bus.s_axis_dividend_tvalid;
  // Remainder stays below the divisor, so its top bit is always zero after a step.
  assign w_unused = r_rem[WIDTH];

  // Operand preparation for a newly accepted start.
  always_comb begin
    w_cnt_init = CW'(WIDTH - 1);
    w_quo_init = bus.s_axis_dividend_tdata;
`ifdef DIV_EARLY_EXIT_EN
    w_lz       = clz(bus.s_axis_dividend_tdata);
    w_byp_init = 1'b0;
    if (bus.s_axis_divisor_tdata == {WIDTH{1'b0}}) begin
      w_cnt_init = {CW{1'b0}};
      w_byp_init = 1'b1;
    end else if (w_lz == CW'(WIDTH)) begin
      w_cnt_init = {CW{1'b0}};
      w_quo_init = {WIDTH{1'b0}};
    end else begin
      w_cnt_init = CW'(WIDTH - 1) - w_lz;
      w_quo_init = bus.s_axis_dividend_tdata << w_lz;
    end
`endif
  end

  // One restoring iteration and the value presented on completion.
  always_comb begin
    w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_trial   = w_shift - {1'b0, r_dvs};
    w_rem_nxt = w_shift;
    w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
    if (!w_trial[WIDTH]) begin
      w_rem_nxt = w_trial;
      w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
    end else begin
      w_rem_nxt = w_shift;
    end
    w_result = {w_quo_nxt, w_rem_nxt[WIDTH-1:0]};
`ifdef DIV_EARLY_EXIT_EN
    if (r_byp) begin
      w_result = {{WIDTH{1'b1}}, r_quo};
    end else begin
      w_result = {w_quo_nxt, w_rem_nxt[WIDTH-1:0]};
    end
`endif
  end

  // Next-state logic; a start in any state (re)starts the operation.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = BUSY;
        else         w_state_nxt = IDLE;
      end
      BUSY: begin
        if (w_start)                  w_state_nxt = BUSY;
        else if (r_cnt == {CW{1'b0}}) w_state_nxt = DONE;
        else                          w_state_nxt = BUSY;
      end
      DONE: begin
        if (w_start) w_state_nxt = BUSY;
        else         w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath, iteration counter and registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= {CW{1'b0}};
      r_rem    <= {(WIDTH+1){1'b0}};
      r_quo    <= {WIDTH{1'b0}};
      r_dvs    <= {WIDTH{1'b0}};
      r_tvalid <= 1'b0;
      r_tdata  <= {(2*WIDTH){1'b0}};
`ifdef DIV_EARLY_EXIT_EN
      r_byp    <= 1'b0;
`endif
    end else begin
      r_tvalid <= 1'b0;
      if (w_start) begin
        r_cnt <= w_cnt_init;
        r_rem <= {(WIDTH+1){1'b0}};
        r_quo <= w_quo_init;
        r_dvs <= bus.s_axis_divisor_tdata;
`ifdef DIV_EARLY_EXIT_EN
        r_byp <= w_byp_init;
`endif
      end else if (r_state == BUSY) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
        if (r_cnt == {CW{1'b0}}) begin
          r_tvalid <= 1'b1;
          r_tdata  <= w_result;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign bus.m_axis_dout_tvalid = r_tvalid;
  assign bus.m_axis_dout_tdata  = r_tdata;
endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter (default or DIV_EARLY_EXIT_EN build).
module tb_div_iter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pulse_cnt;
  int   lat;
  int   p0;

  div_iter_if #(.WIDTH(32)) bus ();

  div_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.m_axis_dout_tvalid) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_EXIT_EN
    int lz;
    lz = 0;
    if (b == 32'd0) return 2;
    for (int i = 31; i >= 0; i--) begin
      if (a[i]) break;
      lz++;
    end
    return ((32 - lz) < 1 ? 1 : 32 - lz) + 1;
`else
    return 33 + 0 * int'(a[0] ^ b[0]);
`endif
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    bus.s_axis_dividend_tdata  = a;
    bus.s_axis_divisor_tdata   = b;
    bus.s_axis_dividend_tvalid = 1'b1;
    bus.s_axis_divisor_tvalid  = 1'b1;
    @(posedge clk);
    #1;
    bus.s_axis_dividend_tvalid = 1'b0;
    bus.s_axis_divisor_tvalid  = 1'b0;
  endtask

  // Returns latency in cycles from the start cycle, or -1 if no pulse in 40 cycles.
  task automatic wait_pulse(output int l);
    l = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.m_axis_dout_tvalid) begin
        l = n + 1;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    start(a, b);
    wait_pulse(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(a, b)));
    check({tag, "_data"}, bus.m_axis_dout_tdata, exp);
    tick(1);
    check({tag, "_single"}, {63'd0, bus.m_axis_dout_tvalid}, 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulse_cnt = 0;
    reset = 1'b1;
    bus.s_axis_dividend_tvalid = 1'b0;
    bus.s_axis_divisor_tvalid  = 1'b0;
    bus.s_axis_dividend_tdata  = 32'd0;
    bus.s_axis_divisor_tdata   = 32'd0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_tvalid", {63'd0, bus.m_axis_dout_tvalid}, 64'd0);
    check("rst_tdata", bus.m_axis_dout_tdata, 64'd0);

    run_op("basic", 32'd100, 32'd7, {32'd14, 32'd2});
    run_op("max_by_1", 32'hFFFF_FFFF, 32'd1, {32'hFFFF_FFFF, 32'd0});
    run_op("by_max", 32'h1234_5678, 32'hFFFF_FFFF, {32'd0, 32'h1234_5678});
    run_op("zero_dvd", 32'd0, 32'd5, {32'd0, 32'd0});
    run_op("div_zero", 32'd5, 32'd0, {32'hFFFF_FFFF, 32'd5});
    run_op("mid", 32'hDEAD_BEEF, 32'd16, {32'h0DEA_DBEE, 32'd15});

    // Restart: the first op must still be in flight after ten cycles.
    p0 = pulse_cnt;
`ifdef DIV_EARLY_EXIT_EN
    start(32'h8000_0064, 32'd7);
`else
    start(32'd100, 32'd7);
`endif
    tick(9);
    start(32'd9, 32'd3);
    wait_pulse(lat);
    check("restart_lat", 64'(lat), 64'(exp_lat(32'd9, 32'd3)));
    check("restart_data", bus.m_axis_dout_tdata, {32'd3, 32'd0});
    tick(3);
    check("restart_pulses", 64'(pulse_cnt - p0), 64'd1);

    // Back-to-back: second start issued in the DONE cycle of the first.
    start(32'd1000, 32'd10);
    wait_pulse(lat);
    check("b2b_first", bus.m_axis_dout_tdata, {32'd100, 32'd0});
    start(32'd7, 32'd2);
    check("b2b_hold_old", bus.m_axis_dout_tdata, {32'd100, 32'd0});
    wait_pulse(lat);
    check("b2b_lat", 64'(lat), 64'(exp_lat(32'd7, 32'd2)));
    check("b2b_second", bus.m_axis_dout_tdata, {32'd3, 32'd1});
    tick(5);
    check("hold_tvalid", {63'd0, bus.m_axis_dout_tvalid}, 64'd0);
    check("hold_tdata", bus.m_axis_dout_tdata, {32'd3, 32'd1});

    // Reset mid-operation abandons it.
    start(32'hFFFF_0064, 32'd7);
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_tvalid", {63'd0, bus.m_axis_dout_tvalid}, 64'd0);
    check("midrst_tdata", bus.m_axis_dout_tdata, 64'd0);
    p0 = pulse_cnt;
    tick(40);
    check("midrst_nopulse", 64'(pulse_cnt - p0), 64'd0);

    // A single tvalid is not a start.
    bus.s_axis_dividend_tdata = 32'd100;
    bus.s_axis_divisor_tdata  = 32'd7;
    bus.s_axis_divisor_tvalid = 1'b1;
    tick(1);
    bus.s_axis_divisor_tvalid  = 1'b0;
    bus.s_axis_dividend_tvalid = 1'b1;
    tick(1);
    bus.s_axis_dividend_tvalid = 1'b0;
    tick(40);
    check("onevalid_nopulse", 64'(pulse_cnt - p0), 64'd0);
    check("onevalid_tdata", bus.m_axis_dout_tdata, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
